price_band_monitor: RTL and testbench
=====================================

# price_band_monitor

Multi-channel, runtime-configurable price threshold detector with per-channel debounce and hysteresis. It accepts a time-multiplexed stream of tagged price samples and keeps a confirmed zone (IDLE/BAND/HIGH/LOW) for each channel. For every accepted sample it emits a registered result with a zone-change event flag. It sits between the market-data parser and the trading-signal logic, and replaces the single-channel fixed-threshold detector.

## Interface
- PRICE_W, 8, price and threshold width (unsigned)
- NUM_CH, 4, number of channels (≥1); CH_W = max(1, $clog2(NUM_CH))
- DEB_W, 4, debounce-count register width
- UPPER_DEF, 105, reset value of every channel's upper threshold
- LOWER_DEF, 95, reset value of every channel's lower threshold
- DEB_DEF, 3, reset value of every channel's debounce count
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_W  channel being configured
- cfg_upper, cfg_lower  in  PRICE_W  new thresholds
- cfg_deb  in  DEB_W  new debounce count
- cfg_err  out  1  one-cycle pulse: config write rejected
- in_valid  in  1  sample strobe, no backpressure
- in_ch  in  CH_W  sample channel
- in_price  in  PRICE_W  sample price
- out_valid  out  1  result strobe
- out_ch  out  CH_W  result channel
- out_zone  out  2  00 IDLE, 01 BAND, 10 LOW, 11 HIGH
- out_event  out  1  confirmed zone changed on this sample
- zone_vec  out  2*NUM_CH  live confirmed zone of every channel; channel i at [2i+1:2i]

## Operation
- Classify each sample against its channel's thresholds: ABOVE if price ≥ upper, BELOW if price ≤ lower, otherwise INSIDE. All comparisons are unsigned.
- Per-channel state: confirmed zone, pending direction (NONE/UP/DOWN), and a debounce counter of DEB_W bits that saturates. An effective debounce value D of 0 is treated as 1.
- INSIDE sample: zone becomes BAND immediately; pending is cleared.
- ABOVE sample, zone ≠ HIGH:
  - If pending is already UP, the counter increments.
  - Otherwise pending becomes UP and the counter is set to 1.
  - When the counter reaches D, zone becomes HIGH and pending is cleared.
- BELOW sample: symmetric to ABOVE, with DOWN and LOW.
- ABOVE in HIGH, or BELOW in LOW: no change.
- Debounce counts consecutive samples of that channel. Samples on other channels and idle cycles do not break the run.
- While a channel is pending, it reports its previous confirmed zone (hysteresis). A channel that has never been confirmed reports IDLE.
- Config write:
  - Rejected if cfg_upper < cfg_lower or cfg_ch ≥ NUM_CH. A rejected write raises cfg_err on the next cycle and changes nothing.
  - An accepted write updates the thresholds and D and clears that channel's pending state and counter. It leaves the confirmed zone unchanged.
- A sample with in_ch ≥ NUM_CH is dropped: no out_valid and no state change.

## Timing
- One-cycle latency: a sample at edge N produces out_valid/out_ch/out_zone/out_event after edge N.
- out_zone is the zone after the sample is applied. zone_vec updates on the same edge.
- Same-cycle config write and sample on the same channel: the sample is evaluated with the old config. The config write then takes effect, and its pending clear overrides the sample's counter update. The zone result from the sample still applies.
- Same-cycle operations on different channels are independent.
- Reset values:
  - Outputs: out_valid = 0, out_event = 0, cfg_err = 0, out_zone = 00, out_ch = 0, zone_vec = 0.
  - Every channel: IDLE, pending NONE, counter 0, thresholds and D at their *_DEF values.
- Reset asserted mid-run overrides everything in that cycle. The first sample after reset deassertion is evaluated normally.

## Structure
- Package price_pkg holds:
  - zone_t enum {IDLE = 2'b00, BAND = 2'b01, LOW = 2'b10, HIGH = 2'b11}
  - pend_t enum {NONE, UP, DOWN}
  - cls_t enum {INSIDE, ABOVE, BELOW}
- Sub-module price_chan_fsm holds one channel's config registers, zone, pending state and counter. Inputs: sample strobe, price, and config write. Outputs: zone and event.
- The top generates NUM_CH instances of price_chan_fsm, demuxes by channel, and registers the output mux.
- Elaboration asserts: NUM_CH ≥ 1, UPPER_DEF ≥ LOWER_DEF, DEB_DEF < 2**DEB_W.

## Test plan
- Reset defaults, ch0 prices 100, 106, 107, 108: zones BAND, BAND, BAND, HIGH. out_event is set on the 1st and 4th samples.
- ch1 prices 94, 93 interleaved with ch2 samples, then ch1 94: ch1 reaches LOW on its 3rd sample. The ch2 samples do not reset the ch1 run.
- ch0 in HIGH, samples 96 then 110: zone becomes BAND immediately, then pending UP. Zone stays BAND with out_event = 0.
- Config write ch3 upper = 50, lower = 60: cfg_err pulses and the ch3 thresholds are unchanged. Then write upper = 60, lower = 50, D = 0, and send sample 60: ch3 goes to HIGH immediately.
- Same-cycle config write on ch0 (upper = 200) and ch0 sample 150 while pending UP with count 2 (D = 3): the sample reaches D under the old threshold, so ch0 goes to HIGH. The next sample 150 is INSIDE under the new threshold, so zone becomes BAND.
- Reset asserted while ch0 is pending: out_valid = 0 and zone_vec = 0. The first sample 100 afterwards gives BAND with out_event = 1.

Source files
------------

// File: rtl/price_pkg.sv
// Shared types for the multi-channel price band monitor.
package price_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BAND = 2'b01,
    LOW  = 2'b10,
    HIGH = 2'b11
  } zone_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } pend_t;

  typedef enum logic [1:0] {
    INSIDE = 2'd0,
    ABOVE  = 2'd1,
    BELOW  = 2'd2
  } cls_t;

endpackage

// File: rtl/price_chan_fsm.sv
// One channel: config registers, confirmed zone, pending direction and
// saturating debounce counter. Exposes the post-sample zone for the top's output mux.
module price_chan_fsm
  import price_pkg::*;
#(
  parameter int PRICE_W   = 8,
  parameter int DEB_W     = 4,
  parameter int UPPER_DEF = 105,
  parameter int LOWER_DEF = 95,
  parameter int DEB_DEF   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_smp_valid,
  input  logic [PRICE_W-1:0] i_price,
  input  logic               i_cfg_we,
  input  logic [PRICE_W-1:0] i_cfg_upper,
  input  logic [PRICE_W-1:0] i_cfg_lower,
  input  logic [DEB_W-1:0]   i_cfg_deb,
  output zone_t              o_zone,
  output zone_t              o_zone_nxt,
  output logic               o_event
);

  logic [PRICE_W-1:0] r_upper;
  logic [PRICE_W-1:0] r_lower;
  logic [DEB_W-1:0]   r_deb;
  logic [DEB_W-1:0]   r_cnt;
  zone_t              r_zone;
  pend_t              r_pend;

  cls_t               w_cls;
  logic [DEB_W-1:0]   w_d;
  logic [DEB_W-1:0]   w_cnt_inc;
  zone_t              w_zone_n;
  pend_t              w_pend_n;
  logic [DEB_W-1:0]   w_cnt_n;

  // ABOVE wins over BELOW when upper == lower == price.
  assign w_cls = (i_price >= r_upper) ? ABOVE :
                 (i_price <= r_lower) ? BELOW : INSIDE;
  assign w_d       = (r_deb == '0) ? DEB_W'(1) : r_deb;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + DEB_W'(1);

  always_comb begin
    w_zone_n = r_zone;
    w_pend_n = r_pend;
    w_cnt_n  = r_cnt;
    if (i_smp_valid) begin
      case (w_cls)
        INSIDE: begin
          w_zone_n = BAND;
          w_pend_n = NONE;
          w_cnt_n  = '0;
        end
        ABOVE: begin
          if (r_zone != HIGH) begin
            w_cnt_n = (r_pend == UP) ? w_cnt_inc : DEB_W'(1);
            if (w_cnt_n >= w_d) begin
              w_zone_n = HIGH;
              w_pend_n = NONE;
              w_cnt_n  = '0;
            end else begin
              w_pend_n = UP;
            end
          end
        end
        BELOW: begin
          if (r_zone != LOW) begin
            w_cnt_n = (r_pend == DOWN) ? w_cnt_inc : DEB_W'(1);
            if (w_cnt_n >= w_d) begin
              w_zone_n = LOW;
              w_pend_n = NONE;
              w_cnt_n  = '0;
            end else begin
              w_pend_n = DOWN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A config write in the same cycle as a sample keeps the sample's zone
  // result but discards its pending/counter update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_upper <= PRICE_W'(UPPER_DEF);
      r_lower <= PRICE_W'(LOWER_DEF);
      r_deb   <= DEB_W'(DEB_DEF);
      r_cnt   <= '0;
      r_zone  <= IDLE;
      r_pend  <= NONE;
    end else begin
      r_zone <= w_zone_n;
      if (i_cfg_we) begin
        r_upper <= i_cfg_upper;
        r_lower <= i_cfg_lower;
        r_deb   <= i_cfg_deb;
        r_pend  <= NONE;
        r_cnt   <= '0;
      end else begin
        r_pend <= w_pend_n;
        r_cnt  <= w_cnt_n;
      end
    end
  end

  assign o_zone     = r_zone;
  assign o_zone_nxt = w_zone_n;
  assign o_event    = i_smp_valid && (w_zone_n != r_zone);

endmodule

// File: rtl/price_band_monitor.sv
// Multi-channel price threshold detector: demuxes samples/config to per-channel
// FSMs and registers the selected channel's result.
module price_band_monitor
  import price_pkg::*;
#(
  parameter int  PRICE_W   = 8,
  parameter int  NUM_CH    = 4,
  parameter int  DEB_W     = 4,
  parameter int  UPPER_DEF = 105,
  parameter int  LOWER_DEF = 95,
  parameter int  DEB_DEF   = 3,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PRICE_W-1:0]  cfg_upper,
  input  logic [PRICE_W-1:0]  cfg_lower,
  input  logic [DEB_W-1:0]    cfg_deb,
  output logic                cfg_err,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [PRICE_W-1:0]  in_price,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [1:0]          out_zone,
  output logic                out_event,
  output logic [2*NUM_CH-1:0] zone_vec
);

  if (NUM_CH < 1) begin : g_chk_numch
    $error("price_band_monitor: NUM_CH must be at least 1");
  end
  if (UPPER_DEF < LOWER_DEF) begin : g_chk_def
    $error("price_band_monitor: UPPER_DEF must be >= LOWER_DEF");
  end
  if (DEB_DEF >= (2 ** DEB_W)) begin : g_chk_deb
    $error("price_band_monitor: DEB_DEF does not fit in DEB_W bits");
  end

  logic  w_smp_ok;
  logic  w_cfg_ok;
  zone_t w_zone     [NUM_CH];
  zone_t w_zone_nxt [NUM_CH];
  logic  w_event    [NUM_CH];

  assign w_smp_ok = in_valid && (int'(in_ch) < NUM_CH);
  assign w_cfg_ok = cfg_we && (cfg_upper >= cfg_lower) && (int'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    price_chan_fsm #(
      .PRICE_W   (PRICE_W),
      .DEB_W     (DEB_W),
      .UPPER_DEF (UPPER_DEF),
      .LOWER_DEF (LOWER_DEF),
      .DEB_DEF   (DEB_DEF)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .i_smp_valid (w_smp_ok && (in_ch == CH_W'(i))),
      .i_price     (in_price),
      .i_cfg_we    (w_cfg_ok && (cfg_ch == CH_W'(i))),
      .i_cfg_upper (cfg_upper),
      .i_cfg_lower (cfg_lower),
      .i_cfg_deb   (cfg_deb),
      .o_zone      (w_zone[i]),
      .o_zone_nxt  (w_zone_nxt[i]),
      .o_event     (w_event[i])
    );
  end

  always_comb begin
    zone_vec = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      zone_vec[2*k +: 2] = w_zone[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_event <= 1'b0;
      cfg_err   <= 1'b0;
      out_zone  <= IDLE;
      out_ch    <= '0;
    end else begin
      out_valid <= w_smp_ok;
      out_event <= 1'b0;
      cfg_err   <= cfg_we && !w_cfg_ok;
      if (w_smp_ok) begin
        out_ch    <= in_ch;
        out_zone  <= w_zone_nxt[in_ch];
        out_event <= w_event[in_ch];
      end
    end
  end

endmodule

// File: tb/tb_price_band_monitor.sv
// Directed self-checking bench for price_band_monitor (default parameters).
module tb_price_band_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_upper;
  logic [7:0] cfg_lower;
  logic [3:0] cfg_deb;
  logic       cfg_err;
  logic       in_valid;
  logic [1:0] in_ch;
  logic [7:0] in_price;
  logic       out_valid;
  logic [1:0] out_ch;
  logic [1:0] out_zone;
  logic       out_event;
  logic [7:0] zone_vec;

  int checks = 0;
  int errors = 0;

  price_band_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_upper (cfg_upper),
    .cfg_lower (cfg_lower),
    .cfg_deb   (cfg_deb),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_price  (in_price),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_zone  (out_zone),
    .out_event (out_event),
    .zone_vec  (zone_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and leave inputs idle, sampling 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic smp(input string tag, input logic [1:0] ch, input logic [7:0] price,
                     input logic [1:0] ezone, input logic eevt);
    in_valid = 1'b1;
    in_ch    = ch;
    in_price = price;
    tick();
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".ch"},    32'(out_ch),    32'(ch));
    chk({tag, ".zone"},  32'(out_zone),  32'(ezone));
    chk({tag, ".event"}, 32'(out_event), 32'(eevt));
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_upper = '0; cfg_lower = '0;
    cfg_deb = '0; in_valid = 1'b0; in_ch = '0; in_price = '0;
    @(negedge clk);
    tick();
    tick();
    chk("rst.valid",   32'(out_valid), 32'd0);
    chk("rst.event",   32'(out_event), 32'd0);
    chk("rst.cfg_err", 32'(cfg_err),   32'd0);
    chk("rst.zone",    32'(out_zone),  32'd0);
    chk("rst.ch",      32'(out_ch),    32'd0);
    chk("rst.zvec",    32'(zone_vec),  32'd0);
    reset = 1'b0;
    tick();
    chk("idle.valid", 32'(out_valid), 32'd0);

    // ch0 debounce up to HIGH (D=3, upper 105)
    smp("c0s100", 2'd0, 8'd100, 2'b01, 1'b1);
    chk("c0.zvec1", 32'(zone_vec), 32'h01);
    smp("c0s106", 2'd0, 8'd106, 2'b01, 1'b0);
    smp("c0s107", 2'd0, 8'd107, 2'b01, 1'b0);
    smp("c0s108", 2'd0, 8'd108, 2'b11, 1'b1);
    chk("c0.zvec2", 32'(zone_vec), 32'h03);

    // ch1 run to LOW, interleaved with ch2 and an idle cycle
    smp("c1s94a", 2'd1, 8'd94, 2'b00, 1'b0);
    smp("c2s100a", 2'd2, 8'd100, 2'b01, 1'b1);
    smp("c1s93", 2'd1, 8'd93, 2'b00, 1'b0);
    smp("c2s100b", 2'd2, 8'd100, 2'b01, 1'b0);
    tick();
    chk("gap.valid", 32'(out_valid), 32'd0);
    smp("c1s94b", 2'd1, 8'd94, 2'b10, 1'b1);
    chk("c1.zvec", 32'(zone_vec), 32'h1B);

    // ch0 hysteresis: drop into band immediately, then pending UP stays BAND
    smp("c0s96", 2'd0, 8'd96, 2'b01, 1'b1);
    smp("c0s110a", 2'd0, 8'd110, 2'b01, 1'b0);
    smp("c0s110b", 2'd0, 8'd110, 2'b01, 1'b0);
    chk("c0.zvec3", 32'(zone_vec), 32'h19);

    // same-cycle config (upper=200) and third ABOVE sample under old threshold
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_upper = 8'd200; cfg_lower = 8'd95; cfg_deb = 4'd3;
    smp("c0cfg150", 2'd0, 8'd150, 2'b11, 1'b1);
    chk("c0cfg.err", 32'(cfg_err), 32'd0);
    smp("c0s150", 2'd0, 8'd150, 2'b01, 1'b1);

    // rejected config on ch3 (upper < lower)
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_upper = 8'd50; cfg_lower = 8'd60; cfg_deb = 4'd3;
    tick();
    chk("rej.err", 32'(cfg_err), 32'd1);
    chk("rej.valid", 32'(out_valid), 32'd0);
    tick();
    chk("rej.err_pulse", 32'(cfg_err), 32'd0);
    smp("c3s100", 2'd3, 8'd100, 2'b01, 1'b1);
    smp("c3s96", 2'd3, 8'd96, 2'b01, 1'b0);

    // accepted config on ch3 with D=0 -> immediate confirm
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_upper = 8'd60; cfg_lower = 8'd50; cfg_deb = 4'd0;
    tick();
    chk("acc.err", 32'(cfg_err), 32'd0);
    chk("acc.zvec", 32'(zone_vec), 32'h59);
    smp("c3s60", 2'd3, 8'd60, 2'b11, 1'b1);
    chk("c3.zvec", 32'(zone_vec), 32'hD9);

    // reset while ch0 pending
    smp("c0s210", 2'd0, 8'd210, 2'b01, 1'b0);
    reset = 1'b1;
    in_valid = 1'b1; in_ch = 2'd0; in_price = 8'd210;
    tick();
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.zvec",  32'(zone_vec),  32'd0);
    chk("mrst.event", 32'(out_event), 32'd0);
    reset = 1'b0;
    smp("post100", 2'd0, 8'd100, 2'b01, 1'b1);
    smp("post106", 2'd0, 8'd106, 2'b01, 1'b0);
    smp("post107", 2'd0, 8'd107, 2'b01, 1'b0);
    smp("post108", 2'd0, 8'd108, 2'b11, 1'b1);
    chk("post.zvec", 32'(zone_vec), 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
